// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared arbiter state encodings, mask width helper and default timing
package hyperbus_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_XFER = 3'b010,
        ST_GAP  = 3'b100
    } arb_state_e;

    localparam int GAP_DEFAULT     = 2;
    localparam int TIMEOUT_DEFAULT = 255;

    function automatic int mask_width(input int dw);
        return dw / 8 + 1;
    endfunction
endpackage

// File: rtl/hyperbus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin one-hot selector, search starts at ptr
module rr_picker #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [N-1:0]   rot;
    logic [N-1:0]   sel;
    logic [2*N-1:0] back;

    // rotate so bit 0 is req[ptr], take the lowest set bit, rotate back
    always_comb begin
        rot = N'({req, req} >> ptr);
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) sel = N'(1) << i;
        back = {sel, sel} << ptr;
        gnt  = back[2*N-1:N];
    end
endmodule

// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: round-robin sharing of one hyperbus controller among NREQ
// burst requesters, with beat counting, data routing and a beat watchdog.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter  int NREQ        = 2,
    parameter  int WIDTH       = 8,
    parameter  int ADDR_LENGTH = 32,
    parameter  int LEN_WIDTH   = 8,
    parameter  int GAP         = GAP_DEFAULT,
    parameter  int TIMEOUT     = TIMEOUT_DEFAULT,
    localparam int DW          = 2 * WIDTH,
    localparam int MW          = mask_width(DW),
    localparam int PW          = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_i,
    input  logic [NREQ-1:0]             req_we_i,
    input  logic [NREQ-1:0]             req_reg_i,
    input  logic [NREQ*ADDR_LENGTH-1:0] req_adr_i,
    input  logic [NREQ*LEN_WIDTH-1:0]   req_len_i,
    input  logic [NREQ*DW-1:0]          req_dat_i,
    input  logic [NREQ*MW-1:0]          req_mask_i,
    output logic [NREQ-1:0]             gnt_o,
    output logic [NREQ-1:0]             req_ready_o,
    output logic [NREQ-1:0]             req_valid_o,
    output logic [DW-1:0]               req_dat_o,
    output logic [NREQ-1:0]             done_o,
    output logic [NREQ-1:0]             err_o,
    output logic [ADDR_LENGTH-1:0]      hb_adr_o,
    output logic [DW-1:0]               hb_dat_o,
    output logic [MW-1:0]               hb_mask_o,
    output logic                        hb_reg_space_o,
    output logic                        hb_wrq_o,
    output logic                        hb_rrq_o,
    input  logic                        hb_ready_i,
    input  logic                        hb_valid_i,
    input  logic [DW-1:0]               hb_dat_i
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP + 1);

    arb_state_e             state_q, state_d;
    logic [NREQ-1:0]        gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [PW-1:0]          gidx_q, gidx_d, ptr_q, ptr_d;
    logic [ADDR_LENGTH-1:0] adr_q, adr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d, beats_q, beats_d;
    logic                   we_q, we_d, reg_q, reg_d, wrq_q, wrq_d, rrq_q, rrq_d;
    logic [WDW-1:0]         wdog_q, wdog_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [NREQ-1:0]        pick;
    logic [PW-1:0]          widx;
    logic [LEN_WIDTH-1:0]   wlen;
    logic                   in_burst, beat, last, expire;

    rr_picker #(.N(NREQ)) u_pick (.req(req_i), .ptr(ptr_q), .gnt(pick));

    always_comb begin
        widx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) widx = PW'(i);
    end

    assign wlen     = req_len_i[widx*LEN_WIDTH +: LEN_WIDTH];
    assign in_burst = state_q == ST_XFER && beats_q < len_q;
    assign beat     = in_burst && (we_q ? hb_ready_i : hb_valid_i);
    assign last     = beat && beats_q == len_q - 1'b1;
    assign expire   = state_q == ST_XFER && !beat && wdog_q == WDW'(TIMEOUT - 1);

    assign gnt_o          = gnt_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign hb_wrq_o       = wrq_q;
    assign hb_rrq_o       = rrq_q;
    assign hb_adr_o       = adr_q;
    assign hb_reg_space_o = reg_q;
    assign req_dat_o      = hb_dat_i;
    assign hb_dat_o       = req_dat_i[gidx_q*DW +: DW];
    // beyond len the controller may still pull a word; masking it writes nothing
    assign hb_mask_o      = (in_burst && we_q) ? req_mask_i[gidx_q*MW +: MW] : '1;
    assign req_ready_o    = (in_burst && we_q && hb_ready_i) ? gnt_q : '0;
    assign req_valid_o    = (in_burst && !we_q && hb_valid_i) ? gnt_q : '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        adr_d   = adr_q;
        len_d   = len_q;
        we_d    = we_q;
        reg_d   = reg_q;
        wrq_d   = wrq_q;
        rrq_d   = rrq_q;
        beats_d = beats_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: if (|req_i) begin
                gnt_d   = pick;
                gidx_d  = widx;
                ptr_d   = widx == PW'(NREQ - 1) ? '0 : widx + 1'b1;
                adr_d   = req_adr_i[widx*ADDR_LENGTH +: ADDR_LENGTH];
                len_d   = wlen == '0 ? LEN_WIDTH'(1) : wlen;
                we_d    = req_we_i[widx];
                reg_d   = req_reg_i[widx];
                wrq_d   = req_we_i[widx];
                rrq_d   = !req_we_i[widx];
                beats_d = '0;
                wdog_d  = '0;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                beats_d = beat ? beats_q + 1'b1 : beats_q;
                wdog_d  = beat ? '0 : wdog_q + 1'b1;
                if (last || expire) begin
                    wrq_d   = 1'b0;
                    rrq_d   = 1'b0;
                    done_d  = gnt_q;
                    err_d   = expire ? gnt_q : '0;
                    gnt_d   = '0;
                    gap_d   = GW'(GAP);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = gap_q <= GW'(1) ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            adr_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            reg_q   <= 1'b0;
            wrq_q   <= 1'b0;
            rrq_q   <= 1'b0;
            beats_q <= '0;
            wdog_q  <= '0;
            gap_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            we_q    <= we_d;
            reg_q   <= reg_d;
            wrq_q   <= wrq_d;
            rrq_q   <= rrq_d;
            beats_q <= beats_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: directed scenario tests for hyperbus_arbiter (NREQ=2, DW=16, MW=3)
module tb_hyperbus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i, req_we_i, req_reg_i;
    logic [63:0] req_adr_i;
    logic [15:0] req_len_i;
    logic [31:0] req_dat_i;
    logic [5:0]  req_mask_i;
    logic [1:0]  gnt_o, req_ready_o, req_valid_o, done_o, err_o;
    logic [15:0] req_dat_o, hb_dat_o, hb_dat_i;
    logic [31:0] hb_adr_o;
    logic [2:0]  hb_mask_o;
    logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o, hb_ready_i, hb_valid_i;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    hyperbus_arbiter dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_we_i(req_we_i), .req_reg_i(req_reg_i),
        .req_adr_i(req_adr_i), .req_len_i(req_len_i), .req_dat_i(req_dat_i),
        .req_mask_i(req_mask_i), .gnt_o(gnt_o), .req_ready_o(req_ready_o),
        .req_valid_o(req_valid_o), .req_dat_o(req_dat_o), .done_o(done_o), .err_o(err_o),
        .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
        .hb_reg_space_o(hb_reg_space_o), .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o),
        .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i), .hb_dat_i(hb_dat_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt_o == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {req_i, req_we_i, req_reg_i, req_adr_i, req_len_i, req_dat_i, req_mask_i} = '0;
        {hb_ready_i, hb_valid_i, hb_dat_i} = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt_o, req_ready_o, req_valid_o, done_o, err_o, hb_wrq_o, hb_rrq_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rdy=%b vld=%b done=%b err=%b wrq=%b rrq=%b exp all 0",
                     gnt_o, req_ready_o, req_valid_o, done_o, err_o, hb_wrq_o, hb_rrq_o);
        end
        checks++;
        if (hb_mask_o !== 3'b111) begin
            errors++;
            $display("FAIL reset_mask got %b exp 111", hb_mask_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        req_adr_i[31:0] = 32'h100;
        req_len_i[7:0]  = 8'd4;
        req_dat_i[15:0] = 16'hA5A5;
        req_mask_i[2:0] = 3'b010;
        req_we_i = 2'b01;
        req_i    = 2'b01;
        @(negedge clk);
        checks++;
        if ({gnt_o, hb_wrq_o, hb_rrq_o} !== 4'b0110 || hb_adr_o !== 32'h100) begin
            errors++;
            $display("FAIL write_grant got gnt=%b wrq=%b rrq=%b adr=%h exp 01 1 0 00000100",
                     gnt_o, hb_wrq_o, hb_rrq_o, hb_adr_o);
        end
        for (int b = 0; b < 4; b++) begin
            hb_ready_i = 1'b1;
            #1;
            checks++;
            if ({req_ready_o, hb_mask_o, hb_dat_o, hb_wrq_o, done_o} !== {2'b01, 3'b010, 16'hA5A5, 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL write_beat%0d got rdy=%b mask=%b dat=%h wrq=%b done=%b exp 01 010 a5a5 1 00",
                         b, req_ready_o, hb_mask_o, hb_dat_o, hb_wrq_o, done_o);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({done_o, err_o, gnt_o, hb_wrq_o} !== 7'b0100000) begin
            errors++;
            $display("FAIL write_done got done=%b err=%b gnt=%b wrq=%b exp 01 00 00 0",
                     done_o, err_o, gnt_o, hb_wrq_o);
        end
        checks++;
        if (hb_mask_o !== 3'b111 || req_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL write_extra_beat got mask=%b rdy=%b exp 111 00", hb_mask_o, req_ready_o);
        end
        req_i      = 2'b00;
        hb_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 2'b00) begin
            errors++;
            $display("FAIL write_done_pulse got %b exp 00", done_o);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read;
        int n;
        int pulses;
        req_adr_i[63:32] = 32'h2000;
        req_len_i[15:8]  = 8'd3;
        req_reg_i = 2'b10;
        req_we_i  = 2'b00;
        req_i     = 2'b10;
        wait_gnt(n);
        checks++;
        if ({gnt_o, hb_wrq_o, hb_rrq_o, hb_reg_space_o} !== 5'b10011 || hb_adr_o !== 32'h2000) begin
            errors++;
            $display("FAIL read_grant got gnt=%b wrq=%b rrq=%b reg=%b adr=%h exp 10 0 1 1 00002000",
                     gnt_o, hb_wrq_o, hb_rrq_o, hb_reg_space_o, hb_adr_o);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            hb_valid_i = 1'b1;
            hb_dat_i   = 16'h1000 + 16'(k);
            #1;
            if (req_valid_o[1]) pulses++;
            if (k < 3) begin
                checks++;
                if (req_valid_o !== 2'b10 || req_dat_o !== 16'h1000 + 16'(k)) begin
                    errors++;
                    $display("FAIL read_beat%0d got vld=%b dat=%h exp 10 %h",
                             k, req_valid_o, req_dat_o, 16'h1000 + 16'(k));
                end
            end
            if (k == 3) begin
                checks++;
                if (hb_rrq_o !== 1'b0 || done_o !== 2'b10) begin
                    errors++;
                    $display("FAIL read_done got rrq=%b done=%b exp 0 10", hb_rrq_o, done_o);
                end
                req_i = 2'b00;
            end
            @(negedge clk);
        end
        hb_valid_i = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL read_pulse_count got %0d exp 3", pulses);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        int done_cyc;
        logic [1:0] exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_len_i = {8'd1, 8'd1};
        req_we_i  = 2'b11;
        req_i     = 2'b11;
        done_cyc  = 0;
        for (int b = 0; b < 4; b++) begin
            exp = (b % 2 == 1) ? 2'b10 : 2'b01;
            wait_gnt(n);
            checks++;
            if (gnt_o !== exp) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", b, gnt_o, exp);
            end
            if (b > 0) begin
                checks++;
                if (cyc - done_cyc < 3) begin
                    errors++;
                    $display("FAIL rr_spacing%0d got %0d cycles exp >= 3", b, cyc - done_cyc);
                end
            end
            hb_ready_i = 1'b1;
            @(negedge clk);
            hb_ready_i = 1'b0;
            checks++;
            if (done_o !== exp) begin
                errors++;
                $display("FAIL rr_done%0d got %b exp %b", b, done_o, exp);
            end
            done_cyc = cyc;
        end
        req_i = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_len_zero;
        int n;
        req_len_i[7:0] = 8'd0;
        req_we_i = 2'b00;
        req_i    = 2'b01;
        wait_gnt(n);
        checks++;
        if (gnt_o !== 2'b01 || hb_rrq_o !== 1'b1) begin
            errors++;
            $display("FAIL len0_grant got gnt=%b rrq=%b exp 01 1", gnt_o, hb_rrq_o);
        end
        hb_valid_i = 1'b1;
        hb_dat_i   = 16'hBEEF;
        #1;
        checks++;
        if (req_valid_o !== 2'b01) begin
            errors++;
            $display("FAIL len0_valid got %b exp 01", req_valid_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done_o, hb_rrq_o, req_valid_o} !== 5'b01000) begin
            errors++;
            $display("FAIL len0_done got done=%b rrq=%b vld=%b exp 01 0 00", done_o, hb_rrq_o, req_valid_o);
        end
        req_i      = 2'b00;
        hb_valid_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_watchdog;
        int n;
        req_len_i[15:8] = 8'd4;
        req_we_i = 2'b00;
        req_i    = 2'b10;
        wait_gnt(n);
        checks++;
        if (gnt_o !== 2'b10) begin
            errors++;
            $display("FAIL wdog_grant got %b exp 10", gnt_o);
        end
        req_i = 2'b00;
        n = 0;
        while (done_o == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL wdog_latency got %0d cycles exp 255", n);
        end
        checks++;
        if ({done_o, err_o, hb_rrq_o} !== 5'b10100) begin
            errors++;
            $display("FAIL wdog_exit got done=%b err=%b rrq=%b exp 10 10 0", done_o, err_o, hb_rrq_o);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        req_len_i[7:0] = 8'd4;
        req_we_i = 2'b01;
        req_i    = 2'b01;
        wait_gnt(n);
        hb_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gnt_o, req_ready_o, req_valid_o, done_o, err_o, hb_wrq_o, hb_rrq_o} !== 12'h000 || hb_mask_o !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid got gnt=%b rdy=%b wrq=%b mask=%b exp 00 00 0 111",
                     gnt_o, req_ready_o, hb_wrq_o, hb_mask_o);
        end
        @(negedge clk);
        rst        = 1'b0;
        hb_ready_i = 1'b0;
        req_we_i   = 2'b00;
        req_i      = 2'b11;
        wait_gnt(n);
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_ptr got %b exp 01", gnt_o);
        end
        req_i = 2'b00;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_len_zero;
        test_watchdog;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
